// File: rtl/rand_pkg.sv
// Shared constants and state encoding for the bounded random sampler.
package rand_pkg;

    localparam int unsigned RAND_W_DEFAULT    = 16;
    localparam int unsigned MAX_RETRY_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADVANCE = 2'd1,
        S_SAMPLE  = 2'd2
    } state_t;

endpackage

// File: rtl/rand_range_sampler_if.sv
// Request/result bundle between a consumer, the LFSR source and the sampler.
interface rand_range_sampler_if
    import rand_pkg::*;
#(
    parameter int unsigned RAND_W = RAND_W_DEFAULT
);

    logic              i_req;
    logic [RAND_W-1:0] i_range;
    logic [RAND_W-1:0] i_rand;
    logic              o_next;
    logic              o_busy;
    logic              o_valid;
    logic [RAND_W-1:0] o_value;
    logic              o_fallback;

    modport slave (
        input  i_req,
        input  i_range,
        input  i_rand,
        output o_next,
        output o_busy,
        output o_valid,
        output o_value,
        output o_fallback
    );

    modport master (
        output i_req,
        output i_range,
        output i_rand,
        input  o_next,
        input  o_busy,
        input  o_valid,
        input  o_value,
        input  o_fallback
    );

endinterface

// File: rtl/range_mask_gen.sv
// Smallest all-ones mask covering (i_range-1); i_range==0 stands for 2^RAND_W.
module range_mask_gen
    import rand_pkg::*;
#(
    parameter int unsigned RAND_W = RAND_W_DEFAULT
) (
    input  logic [RAND_W-1:0] i_range,
    output logic [RAND_W-1:0] o_mask,
    output logic              o_full
);

    logic [RAND_W-1:0] bound;
    logic              seen;

    assign bound  = i_range - RAND_W'(1);
    assign o_full = (i_range == '0);

    // Scan from the MSB down: every bit at or below the leading one is set.
    always_comb begin
        seen   = 1'b0;
        o_mask = '0;
        for (int unsigned k = 0; k < RAND_W; k++) begin
            seen                 = seen | bound[RAND_W-1-k];
            o_mask[RAND_W-1-k]   = seen;
        end
    end

endmodule

// File: rtl/rand_range_sampler.sv
// Mask-and-reject sampler producing an unbiased value in [0, range) from an LFSR stream.
module rand_range_sampler
    import rand_pkg::*;
#(
    parameter int unsigned RAND_W    = RAND_W_DEFAULT,
    parameter int unsigned MAX_RETRY = MAX_RETRY_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    rand_range_sampler_if.slave  bus
);

    state_t            state_q, state_d;
    logic [RAND_W-1:0] range_q, range_d;
    logic [RAND_W-1:0] mask_q, mask_d;
    logic              full_q, full_d;
    logic [7:0]        retry_q, retry_d;
    logic [RAND_W-1:0] value_q, value_d;
    logic              valid_q, valid_d;
    logic              fallback_q, fallback_d;

    logic [RAND_W-1:0] gen_mask;
    logic              gen_full;
    logic [RAND_W-1:0] cand;
    logic [8:0]        retry_inc;

    range_mask_gen #(.RAND_W(RAND_W)) u_mask (
        .i_range (bus.i_range),
        .o_mask  (gen_mask),
        .o_full  (gen_full)
    );

    assign cand      = bus.i_rand & mask_q;
    assign retry_inc = {1'b0, retry_q} + 9'd1;

    assign bus.o_next     = (state_q == S_ADVANCE);
    assign bus.o_busy     = (state_q != S_IDLE);
    assign bus.o_valid    = valid_q;
    assign bus.o_value    = value_q;
    assign bus.o_fallback = fallback_q;

    always_comb begin
        state_d    = state_q;
        range_d    = range_q;
        mask_d     = mask_q;
        full_d     = full_q;
        retry_d    = retry_q;
        value_d    = value_q;
        fallback_d = fallback_q;
        valid_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_req) begin
                    range_d = bus.i_range;
                    mask_d  = gen_mask;
                    full_d  = gen_full;
                    retry_d = '0;
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (full_q || (cand < range_q)) begin
                    value_d    = cand;
                    fallback_d = 1'b0;
                    valid_d    = 1'b1;
                    state_d    = S_IDLE;
                end else if (retry_inc < 9'(MAX_RETRY)) begin
                    retry_d = retry_inc[7:0];
                    state_d = S_ADVANCE;
                end else begin
                    // mask < 2*range, so a rejected candidate minus range is in [0, range).
                    value_d    = cand - range_q;
                    fallback_d = 1'b1;
                    valid_d    = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            range_q    <= '0;
            mask_q     <= '0;
            full_q     <= 1'b0;
            retry_q    <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            fallback_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            range_q    <= range_d;
            mask_q     <= mask_d;
            full_q     <= full_d;
            retry_q    <= retry_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            fallback_q <= fallback_d;
        end
    end

endmodule

// File: tb/tb_rand_range_sampler.sv
// Directed bench for rand_range_sampler: two instances (MAX_RETRY 8 and 2) run in lockstep.
module tb_rand_range_sampler;
    import rand_pkg::*;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rand_range_sampler_if #(.RAND_W(W)) bus8 ();
    rand_range_sampler_if #(.RAND_W(W)) bus2 ();

    rand_range_sampler #(.RAND_W(W), .MAX_RETRY(8)) dut8 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus8)
    );

    rand_range_sampler #(.RAND_W(W), .MAX_RETRY(2)) dut2 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus2)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] script [8];
    bit          use_lfsr = 1'b0;
    logic [15:0] lfsr = 16'hACE1;
    int unsigned nxt8 = 0, nxt2 = 0;
    int unsigned base8 = 0, base2 = 0;

    function automatic logic [15:0] pick(input int unsigned k);
        return (k < 8) ? script[k] : 16'h0000;
    endfunction

    // Sixteen Galois steps per draw so consecutive words are not simple shifts.
    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        logic [15:0] t;
        t = s;
        for (int unsigned i = 0; i < 16; i++)
            t = t[0] ? ((t >> 1) ^ 16'hB400) : (t >> 1);
        return t;
    endfunction

    always @(posedge clk) begin
        if (bus8.o_next) begin
            lfsr        <= lfsr_adv(lfsr);
            bus8.i_rand <= use_lfsr ? lfsr_adv(lfsr) : pick(nxt8 - base8);
            nxt8        <= nxt8 + 1;
        end
    end

    always @(posedge clk) begin
        if (bus2.o_next) begin
            bus2.i_rand <= pick(nxt2 - base2);
            nxt2        <= nxt2 + 1;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic drive_req(input logic req, input logic [15:0] rng);
        bus8.i_req   = req;
        bus2.i_req   = req;
        bus8.i_range = rng;
        bus2.i_range = rng;
    endtask

    task automatic load_script(input logic [15:0] r0, input logic [15:0] r1,
                               input logic [15:0] r2, input logic [15:0] r3);
        for (int unsigned i = 0; i < 8; i++) script[i] = 16'h0000;
        script[0] = r0;
        script[1] = r1;
        script[2] = r2;
        script[3] = r3;
        base8 = nxt8;
        base2 = nxt2;
    endtask

    typedef struct {
        logic [15:0] rng;
        logic [15:0] r0;
        logic [15:0] r1;
        logic [15:0] v8;
        int unsigned n8;
        logic [15:0] v2;
        int unsigned n2;
        logic        f2;
    } vec_t;

    vec_t vecs [11];

    task automatic run_vec(input vec_t v, input int unsigned id);
        int unsigned lat8 = 0, lat2 = 0, p8 = 0, p2 = 0;
        logic [15:0] val8 = '0, val2 = '0;
        logic        fb8 = 1'b0, fb2 = 1'b0;
        @(negedge clk);
        load_script(v.r0, v.r1, 16'h0000, 16'h0000);
        drive_req(1'b1, v.rng);
        @(negedge clk);
        drive_req(1'b0, 16'h0000);
        for (int unsigned c = 1; c <= 10; c++) begin
            if (bus8.o_valid) begin
                p8++;
                if (lat8 == 0) begin lat8 = c; val8 = bus8.o_value; fb8 = bus8.o_fallback; end
            end
            if (bus2.o_valid) begin
                p2++;
                if (lat2 == 0) begin lat2 = c; val2 = bus2.o_value; fb2 = bus2.o_fallback; end
            end
            @(negedge clk);
        end
        chk($sformatf("v%0d_value8", id), val8, v.v8);
        chk($sformatf("v%0d_fallback8", id), fb8, 0);
        chk($sformatf("v%0d_nexts8", id), nxt8 - base8, v.n8);
        chk($sformatf("v%0d_latency8", id), lat8, 1 + 2 * v.n8);
        chk($sformatf("v%0d_pulses8", id), p8, 1);
        chk($sformatf("v%0d_value2", id), val2, v.v2);
        chk($sformatf("v%0d_fallback2", id), fb2, v.f2);
        chk($sformatf("v%0d_nexts2", id), nxt2 - base2, v.n2);
        chk($sformatf("v%0d_latency2", id), lat2, 1 + 2 * v.n2);
        chk($sformatf("v%0d_pulses2", id), p2, 1);
    endtask

    initial begin
        int unsigned cnt8, cnt2, got, oob;
        int unsigned bucket [6];
        logic [15:0] seen [4];

        //            range     r0        r1        v8        n8  v2        n2  f2
        vecs[0]  = '{16'd10,   16'h1235, 16'h0000, 16'd5,    1, 16'd5,    1, 1'b0};
        vecs[1]  = '{16'd10,   16'h000C, 16'h0007, 16'd7,    2, 16'd7,    2, 1'b0};
        vecs[2]  = '{16'd1,    16'hABCD, 16'h0000, 16'd0,    1, 16'd0,    1, 1'b0};
        vecs[3]  = '{16'd0,    16'hBEEF, 16'h0000, 16'hBEEF, 1, 16'hBEEF, 1, 1'b0};
        vecs[4]  = '{16'd6,    16'h0006, 16'h0003, 16'd3,    2, 16'd3,    2, 1'b0};
        vecs[5]  = '{16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF, 1, 16'h7FFF, 1, 1'b0};
        vecs[6]  = '{16'h8001, 16'h8001, 16'h1234, 16'h1234, 2, 16'h1234, 2, 1'b0};
        vecs[7]  = '{16'd16,   16'h00FF, 16'h0000, 16'd15,   1, 16'd15,   1, 1'b0};
        vecs[8]  = '{16'd10,   16'h000E, 16'h000F, 16'd0,    3, 16'd5,    2, 1'b1};
        vecs[9]  = '{16'd6,    16'h0007, 16'h0006, 16'd0,    3, 16'd0,    2, 1'b1};
        vecs[10] = '{16'h8001, 16'hFFFF, 16'hFFFF, 16'd0,    3, 16'h7FFE, 2, 1'b1};

        for (int unsigned i = 0; i < 8; i++) script[i] = 16'h0000;
        drive_req(1'b0, 16'h0000);
        repeat (2) @(negedge clk);
        chk("reset_outputs8", {bus8.o_next, bus8.o_busy, bus8.o_valid, bus8.o_fallback, bus8.o_value}, 0);
        chk("reset_outputs2", {bus2.o_next, bus2.o_busy, bus2.o_valid, bus2.o_fallback, bus2.o_value}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int unsigned i = 0; i < 11; i++) run_vec(vecs[i], i);

        // req held high: a new accept in every o_valid cycle gives one result per 3 cycles.
        @(negedge clk);
        load_script(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        drive_req(1'b1, 16'h0000);
        @(negedge clk);
        cnt8 = 0; cnt2 = 0;
        for (int unsigned c = 1; c <= 12; c++) begin
            if (bus8.o_valid) begin
                if (cnt8 < 4) seen[cnt8] = bus8.o_value;
                cnt8++;
            end
            if (bus2.o_valid) cnt2++;
            @(negedge clk);
        end
        drive_req(1'b0, 16'h0000);
        chk("b2b_count8", cnt8, 4);
        chk("b2b_count2", cnt2, 4);
        chk("b2b_val0", seen[0], 16'h1111);
        chk("b2b_val1", seen[1], 16'h2222);
        chk("b2b_val2", seen[2], 16'h3333);
        chk("b2b_val3", seen[3], 16'h4444);
        repeat (6) @(negedge clk);

        // req and range wiggled while busy must neither queue a request nor alter the bound.
        load_script(16'h1235, 16'h0000, 16'h0000, 16'h0000);
        drive_req(1'b1, 16'd10);
        @(negedge clk);
        cnt8 = 0; cnt2 = 0;
        for (int unsigned c = 1; c <= 10; c++) begin
            if (c == 1) drive_req(1'b1, 16'h0000);
            if (c == 2) drive_req(1'b0, 16'h0000);
            if (bus8.o_valid) begin cnt8++; seen[0] = bus8.o_value; end
            if (bus2.o_valid) cnt2++;
            @(negedge clk);
        end
        chk("busy_ignore_count8", cnt8, 1);
        chk("busy_ignore_count2", cnt2, 1);
        chk("busy_range_hold", seen[0], 16'd5);
        chk("busy_ignore_nexts", nxt8 - base8, 1);

        // Asynchronous reset while in S_SAMPLE.
        load_script(16'h1235, 16'h0000, 16'h0000, 16'h0000);
        drive_req(1'b1, 16'd10);
        @(negedge clk);
        drive_req(1'b0, 16'h0000);
        @(negedge clk);
        chk("rst_pre_busy", {bus8.o_busy, bus8.o_next}, 2'b10);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs8", {bus8.o_next, bus8.o_busy, bus8.o_valid, bus8.o_fallback, bus8.o_value}, 0);
        chk("rst_mid_outputs2", {bus2.o_next, bus2.o_busy, bus2.o_valid, bus2.o_fallback, bus2.o_value}, 0);
        @(negedge clk);
        rst = 1'b0;
        cnt8 = 0;
        for (int unsigned c = 0; c < 6; c++) begin
            if (bus8.o_valid || bus2.o_valid) cnt8++;
            @(negedge clk);
        end
        chk("rst_no_valid", cnt8, 0);

        // Statistical run with a bench LFSR standing in for the real source.
        use_lfsr = 1'b1;
        for (int unsigned i = 0; i < 6; i++) bucket[i] = 0;
        got = 0; oob = 0;
        drive_req(1'b1, 16'd6);
        for (int unsigned c = 0; c < 10000 && got < 1000; c++) begin
            @(negedge clk);
            if (bus8.o_valid) begin
                if (bus8.o_value < 6) bucket[bus8.o_value]++;
                else oob++;
                got++;
                if (got == 1000) drive_req(1'b0, 16'h0000);
            end
        end
        drive_req(1'b0, 16'h0000);
        chk("lfsr_sample_count", got, 1000);
        chk("lfsr_out_of_range", oob, 0);
        for (int unsigned i = 0; i < 6; i++)
            chk_rng($sformatf("lfsr_bucket%0d", i), bucket[i], 125, 208);
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
